qspi_bus_arbiter: RTL and testbench
===================================

QSPI_BUS_ARBITER -- requirements
Module: qspi_bus_arbiter

Interface
REQ-001 Parameter CSH_CYCLES, default 4: the number of clocks the bus is held deselected (flash_sel=1, flash_clk=0, flash_dir=0) between two owners; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: the maximum number of clocks one master may hold a grant continuously; legal range 16..65535.
REQ-003 clk  input  1  single system clock (16 MHz domain); all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 m_req  input  2  per-master bus request; index 0 is the CPU XIP/flash controller, index 1 is the flash programmer.
REQ-006 m_gnt  output  2  per-master grant; one-hot or zero.
REQ-007 m_clk, m_sel  input  2 each  per-master SPI clock and chip select (active-low).
REQ-008 m_d_out, m_d_dir  input  2x4 each  per-master QSPI data out and output enable.
REQ-009 m_d_in  output  4  pin data in, broadcast to both masters.
REQ-010 flash_clk, flash_sel  output  1 each  to the pin buffers.
REQ-011 flash_d_out, flash_d_dir  output  4 each  to the SB_IO tristate buffers.
REQ-012 flash_d_in  input  4  from the SB_IO buffers.
REQ-013 m_blocked  output  2  asserted when m_req[n]=1 and m_gnt[n]=0.
REQ-014 busy  output  1  asserted when the state is not IDLE.
REQ-015 timeout  output  1  one-clock pulse on a forced revoke.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1, GAP. The state and the round-robin pointer are registers.
REQ-017 Grant rule in IDLE:
  - One master requesting: go to OWN of that master.
  - Both requesting: grant the master not served last; last-served resets to 1, so master 0 wins the first tie.
  - Grant latency: m_gnt is asserted exactly 1 clock after m_req is first sampled high in IDLE.
REQ-018 m_gnt[n] = (state==OWNn); this is decoded from the registered state only.
REQ-019 Pin mux in OWNn passes master n's clk, sel, d_out and d_dir to the pins combinationally from the registered state, with no added latency. In IDLE and GAP the pins are sel=1, clk=0, d_out=0, d_dir=0.
REQ-020 m_d_in = flash_d_in unconditionally.
REQ-021 In OWNn, if m_req[n] drops, go to GAP on the next clock and load the gap counter with CSH_CYCLES-1.
REQ-022 If the owner drops m_req while its m_sel is low, the transfer is aborted: the pins are still forced idle on the GAP entry clock.
REQ-023 GAP counts down to 0, then goes to IDLE. A pending request is granted at the earliest on the clock after IDLE is entered, so the total deselect time is at least CSH_CYCLES+1 clocks.
REQ-024 Hold counter (16 bit):
  - Cleared on entry to OWNn; increments each clock in OWNn.
  - On reaching TIMEOUT_CYCLES-1: go to GAP, pulse timeout, and set lockout[n].
REQ-025 lockout[n] masks m_req[n] out of arbitration until m_req[n] is sampled low, which clears it.
REQ-026 Simultaneous events:
  - The owner dropping its request on the timeout clock is a normal release: no timeout pulse, no lockout.
  - A new request from the other master during OWN or GAP waits; it does not preempt.
REQ-027 The last-served pointer is updated on every grant.
REQ-028 m_blocked and busy are combinational from the registers and m_req.

Reset
REQ-029 While rst_n=0 the block SHALL be in this state:
  - Registers: state=IDLE, gap counter=0, hold counter=0, lockout=0, last-served=1.
  - Outputs: m_gnt=0, timeout=0, busy=0, flash_sel=1, flash_clk=0, flash_d_out=0, flash_d_dir=0.
REQ-030 Reset asserted in the middle of a transfer SHALL release the pins immediately (asynchronously) to the idle values. No GAP is inserted after reset.

Structure
REQ-031 The state enum, the master index constants (MST_CPU=0, MST_PROG=1) and the default CSH/TIMEOUT constants SHALL live in the shared globals package.
REQ-032 The design is one module with no sub-modules. The pin mux is inline.

Verification
REQ-033 Single request:
  - Stimulus: m_req=01 at cycle 0.
  - Response: m_gnt=01 at cycle 1; flash_sel follows m_sel[0] from cycle 1.
REQ-034 Tie and round-robin (CSH_CYCLES=4):
  - Stimulus: m_req=11 out of reset.
  - Response: master 0 is granted first. After it releases, m_gnt=00 for 5 clocks, then m_gnt=10.
  - A second tie after that grants master 0.
REQ-035 Forced timeout (TIMEOUT_CYCLES=16):
  - Stimulus: master 1 holds its request.
  - Response: timeout pulses at the 16th owned clock and m_gnt drops.
  - Master 1 is not regranted until m_req[1] toggles 0->1.
  - m_blocked[1]=1 during the lockout.
REQ-036 Abort mid-byte: drop m_req[0] while m_sel[0]=0 -> flash_sel=1 and flash_d_dir=0 on the next clock; busy=1 through GAP.
REQ-037 Asynchronous reset mid-transfer:
  - Stimulus: assert rst_n=0 mid-transfer, between clock edges.
  - Response: flash_sel=1 and m_gnt=00 without waiting for a clock edge.
  - After release, m_req=10 is granted 1 clock later.

Source files
------------

// File: rtl/qspi_bus_arbiter_pkg.sv
// Shared definitions for the two-master QSPI flash bus arbiter.
package qspi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  localparam int MST_CPU  = 0;
  localparam int MST_PROG = 1;

  localparam int CSH_CYCLES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

endpackage

// File: rtl/qspi_bus_arbiter.sv
// Round-robin owner of the shared QSPI flash pins between the CPU XIP
// controller and the flash programmer, with deselect gap and hold timeout.
module qspi_bus_arbiter
  import qspi_bus_arbiter_pkg::*;
#(
  parameter int CSH_CYCLES     = CSH_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      m_req,
  output logic [1:0]      m_gnt,
  input  logic [1:0]      m_clk,
  input  logic [1:0]      m_sel,
  input  logic [1:0][3:0] m_d_out,
  input  logic [1:0][3:0] m_d_dir,
  output logic [3:0]      m_d_in,
  output logic            flash_clk,
  output logic            flash_sel,
  output logic [3:0]      flash_d_out,
  output logic [3:0]      flash_d_dir,
  input  logic [3:0]      flash_d_in,
  output logic [1:0]      m_blocked,
  output logic            busy,
  output logic            timeout
);

  arb_state_t  r_state;
  logic        r_last;
  logic [3:0]  r_gap;
  logic [15:0] r_hold;
  logic [1:0]  r_lockout;
  logic        r_timeout;

  logic [1:0]  w_req;
  logic        w_pick;
  logic        w_own_idx;
  logic        w_hold_max;

  // Locked-out masters are invisible to arbitration until they drop m_req.
  assign w_req      = m_req & ~r_lockout;
  assign w_pick     = (&w_req) ? ~r_last : w_req[MST_PROG];
  assign w_own_idx  = (r_state == ST_OWN1);
  assign w_hold_max = (r_hold == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_gap     <= '0;
      r_hold    <= '0;
      r_lockout <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_lockout <= r_lockout & m_req;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state <= w_pick ? ST_OWN1 : ST_OWN0;
            r_last  <= w_pick;
            r_hold  <= '0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // A release on the timeout clock wins: no pulse, no lockout.
          if (!m_req[w_own_idx]) begin
            r_state <= ST_GAP;
            r_gap   <= 4'(CSH_CYCLES - 1);
          end else if (w_hold_max) begin
            r_state              <= ST_GAP;
            r_gap                <= 4'(CSH_CYCLES - 1);
            r_timeout            <= 1'b1;
            r_lockout[w_own_idx] <= 1'b1;
          end else begin
            r_hold <= r_hold + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_gap == 4'd0) r_state <= ST_IDLE;
          else               r_gap   <= r_gap - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pins follow the registered owner, so an async reset idles them at once.
  always_comb begin
    flash_clk   = 1'b0;
    flash_sel   = 1'b1;
    flash_d_out = '0;
    flash_d_dir = '0;
    if (r_state == ST_OWN0 || r_state == ST_OWN1) begin
      flash_clk   = m_clk[w_own_idx];
      flash_sel   = m_sel[w_own_idx];
      flash_d_out = m_d_out[w_own_idx];
      flash_d_dir = m_d_dir[w_own_idx];
    end
  end

  assign m_gnt     = {r_state == ST_OWN1, r_state == ST_OWN0};
  assign m_d_in    = flash_d_in;
  assign m_blocked = m_req & ~m_gnt;
  assign busy      = (r_state != ST_IDLE);
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Scoreboard bench for qspi_bus_arbiter: per-cycle expected grant/pin values
// are queued as stimulus is applied and compared after the DUT settles.
module tb_qspi_bus_arbiter;

  localparam int CSH = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      m_req = 2'b00;
  logic [1:0]      m_gnt;
  logic [1:0]      m_clk = 2'b00;
  logic [1:0]      m_sel = 2'b11;
  logic [1:0][3:0] m_d_out = '0;
  logic [1:0][3:0] m_d_dir = '0;
  logic [3:0]      m_d_in;
  logic            flash_clk, flash_sel;
  logic [3:0]      flash_d_out, flash_d_dir;
  logic [3:0]      flash_d_in = 4'h0;
  logic [1:0]      m_blocked;
  logic            busy, timeout;

  qspi_bus_arbiter #(.CSH_CYCLES(CSH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_gnt(m_gnt),
    .m_clk(m_clk), .m_sel(m_sel), .m_d_out(m_d_out), .m_d_dir(m_d_dir),
    .m_d_in(m_d_in), .flash_clk(flash_clk), .flash_sel(flash_sel),
    .flash_d_out(flash_d_out), .flash_d_dir(flash_d_dir),
    .flash_d_in(flash_d_in), .m_blocked(m_blocked), .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] gnt;
    logic [17:0] io;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected observable vector given the owner the spec says should hold the bus.
  function automatic logic [17:0] exp_io(input logic [1:0] g, input logic [1:0] req,
                                         input logic b, input logic t);
    logic s, c;
    logic [3:0] o, d;
    s = 1'b1; c = 1'b0; o = 4'h0; d = 4'h0;
    if (g == 2'b01) begin
      s = m_sel[0]; c = m_clk[0]; o = m_d_out[0]; d = m_d_dir[0];
    end else if (g == 2'b10) begin
      s = m_sel[1]; c = m_clk[1]; o = m_d_out[1]; d = m_d_dir[1];
    end
    return {req & ~g, b, t, s, c, o, d, flash_d_in};
  endfunction

  function automatic logic [17:0] act_io();
    return {m_blocked, busy, timeout, flash_sel, flash_clk, flash_d_out, flash_d_dir, m_d_in};
  endfunction

  task automatic tk(input string tag, input logic [1:0] req, input logic [1:0] sel,
                    input logic [1:0] eg, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    m_req      = req;
    m_sel      = sel;
    m_clk      = 2'($urandom);
    m_d_out    = 8'($urandom);
    m_d_dir    = 8'($urandom);
    flash_d_in = 4'($urandom);
    e.tag = tag;
    e.gnt = eg;
    e.io  = exp_io(eg, req, eb, et);
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".gnt"}, 32'(m_gnt), 32'(e.gnt));
      chk({e.tag, ".io"}, 32'(act_io()), 32'(e.io));
    end
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst.gnt", 32'(m_gnt), 32'd0);
    chk("rst.io", 32'({timeout, busy, flash_sel, flash_clk, flash_d_out, flash_d_dir}),
        32'({1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0}));
    #1 rst_n = 1'b1;

    // Single request, then abort mid-byte with chip select still low
    tk("s.idle", 2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("s.own",  2'b01, 2'b10, 2'b01, 1'b1, 1'b0);
    tk("s.own2", 2'b01, 2'b10, 2'b01, 1'b1, 1'b0);
    tk("ab.drop", 2'b00, 2'b10, 2'b01, 1'b1, 1'b0);
    tk("ab.gap0", 2'b00, 2'b10, 2'b00, 1'b1, 1'b0);
    repeat (CSH - 1) tk("ab.gap", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    tk("ab.idle", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);

    // Tie out of reset, round robin, gap length, second tie
    pulse_reset();
    tk("t.idle", 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
    repeat (3) tk("t.own0", 2'b11, 2'b10, 2'b01, 1'b1, 1'b0);
    tk("t.rel0", 2'b10, 2'b11, 2'b01, 1'b1, 1'b0);
    repeat (CSH) tk("t.gap", 2'b10, 2'b11, 2'b00, 1'b1, 1'b0);
    tk("t.idle1", 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    repeat (2) tk("t.own1", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);
    tk("t.rel1", 2'b00, 2'b11, 2'b10, 1'b1, 1'b0);
    repeat (CSH) tk("t.gap2", 2'b11, 2'b11, 2'b00, 1'b1, 1'b0);
    tk("t.idle2", 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("t.tie2", 2'b11, 2'b11, 2'b01, 1'b1, 1'b0);

    // Forced timeout and lockout of master 1
    pulse_reset();
    tk("to.idle", 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    repeat (TMO) tk("to.own", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);
    tk("to.pulse", 2'b10, 2'b01, 2'b00, 1'b1, 1'b1);
    repeat (CSH - 1) tk("to.gap", 2'b10, 2'b11, 2'b00, 1'b1, 1'b0);
    repeat (3) tk("to.lock", 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("to.low", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("to.req", 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("to.regnt", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);

    // Release exactly on the timeout clock: normal release, no lockout
    repeat (TMO - 2) tk("rl.own", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);
    tk("rl.drop", 2'b00, 2'b01, 2'b10, 1'b1, 1'b0);
    tk("rl.gap0", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    repeat (CSH - 1) tk("rl.gap", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    tk("rl.idle", 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("rl.gnt", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a transfer
    tk("ar.own", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.sel",  32'(flash_sel), 32'd1);
    chk("ar.gnt",  32'(m_gnt), 32'd0);
    chk("ar.busy", 32'(busy), 32'd0);
    chk("ar.dir",  32'(flash_d_dir), 32'd0);
    #3 rst_n = 1'b1;
    tk("ar.idle", 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    tk("ar.gnt1", 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
